keypad_scan: RTL and testbench



---
 rtl/keypad_scan.sv | 125 ++++++++++++
 tb/tb_keypad_scan.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// CHIP-8 4x4 hex keypad scanner: column drive, row sync,
// frame debounce, stable key map and press events.
module keypad_scan #(
  parameter int SCAN_DIV = 1000,
  parameter int DEBOUNCE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rows,
  output logic [3:0]  cols,
  output logic [15:0] keys,
  output logic        any_key,
  output logic        key_event,
  output logic [3:0]  key_code
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] DB_MAX = SW'(DEBOUNCE);

  logic [3:0]    sync1_q, sync2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    col_q, col_d;
  logic [3:0]    cols_q, cols_d;
  logic [15:0]   raw_q, raw_d;
  logic [15:0]   prev_q, prev_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [15:0]   keys_q, keys_d;
  logic          any_q, any_d;
  logic          evt_q, evt_d;
  logic [3:0]    code_q, code_d;

  logic [3:0]    rows_s;
  logic          sample;
  logic          frame_end;
  logic [15:0]   rise;
  logic [3:0]    low;

  assign rows_s    = ~sync2_q;
  assign sample    = (cnt_q == CNT_LAST);
  assign frame_end = sample && (col_q == 2'd3);

  always_comb begin
    cnt_d    = sample ? '0 : cnt_q + 1'b1;
    col_d    = col_q;
    cols_d   = cols_q;
    raw_d    = raw_q;
    prev_d   = prev_q;
    stable_d = stable_q;
    keys_d   = keys_q;
    any_d    = any_q;
    evt_d    = 1'b0;
    code_d   = code_q;
    rise     = '0;
    low      = '0;

    if (sample) begin
      for (int r = 0; r < 4; r++) begin
        raw_d[{2'(r), col_q}] = rows_s[r];
      end
      col_d  = col_q + 2'd1;
      cols_d = ~(4'b0001 << col_d);
    end

    if (frame_end) begin
      if (raw_d == prev_q) begin
        stable_d = (stable_q == DB_MAX) ? stable_q : stable_q + 1'b1;
      end else begin
        stable_d = '0;
      end
      prev_d = raw_d;
      rise   = raw_d & ~keys_q;
      for (int i = 15; i >= 0; i--) begin
        if (rise[i]) low = 4'(i);
      end
      // Debounced map only moves once the matrix has held still
      if (stable_d == DB_MAX && raw_d != keys_q) begin
        keys_d = raw_d;
        any_d  = |raw_d;
        if (|rise) begin
          evt_d  = 1'b1;
          code_d = low;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      cnt_q    <= '0;
      col_q    <= '0;
      cols_q   <= 4'b1110;
      raw_q    <= '0;
      prev_q   <= '0;
      stable_q <= '0;
      keys_q   <= '0;
      any_q    <= 1'b0;
      evt_q    <= 1'b0;
      code_q   <= '0;
    end else begin
      sync1_q  <= rows;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      col_q    <= col_d;
      cols_q   <= cols_d;
      raw_q    <= raw_d;
      prev_q   <= prev_d;
      stable_q <= stable_d;
      keys_q   <= keys_d;
      any_q    <= any_d;
      evt_q    <= evt_d;
      code_q   <= code_d;
    end
  end

  assign cols      = cols_q;
  assign keys      = keys_q;
  assign any_key   = any_q;
  assign key_event = evt_q;
  assign key_code  = code_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: matrix model, frame-level reference,
// directed scenarios and randomized key/bounce traffic.
module tb_keypad_scan;

  localparam int SD = 4;
  localparam int DB = 2;
  localparam int FR = 4 * SD;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [15:0] keys;
  logic        any_key;
  logic        key_event;
  logic [3:0]  key_code;
  logic [15:0] mat = '0;

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk(clk),
    .reset(reset),
    .rows(rows),
    .cols(cols),
    .keys(keys),
    .any_key(any_key),
    .key_event(key_event),
    .key_code(key_code)
  );

  always #5 clk = ~clk;

  // Matrix: a row is pulled low by any pressed key on a driven column
  always_comb begin
    rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      rows[r] = ~|(mat[r*4 +: 4] & ~cols);
    end
  end

  int          checks = 0;
  int          failures = 0;
  int          evt_cnt = 0;
  int          evt_edge = 0;
  int          n;
  logic [15:0] p1, p2;
  logic [15:0] m_raw, m_prev, m_keys;
  int          m_stable;
  logic        m_any, m_evt;
  logic [3:0]  m_code;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    n = 0; p1 = '0; p2 = '0;
    m_raw = '0; m_prev = '0; m_keys = '0;
    m_stable = 0; m_any = 1'b0; m_evt = 1'b0; m_code = '0;
  endtask

  // One clock edge of the frame-level reference
  task automatic model_edge();
    int c;
    logic [15:0] rise;
    n++;
    m_evt = 1'b0;
    if (n % SD == 0) begin
      c = (n / SD - 1) % 4;
      for (int r = 0; r < 4; r++) m_raw[r*4 + c] = p2[r*4 + c];
      if (c == 3) begin
        if (m_raw == m_prev) m_stable = (m_stable + 1 > DB) ? DB : m_stable + 1;
        else m_stable = 0;
        m_prev = m_raw;
        if (m_stable == DB && m_raw != m_keys) begin
          rise = m_raw & ~m_keys;
          m_keys = m_raw;
          m_any = |m_raw;
          if (rise != 0) begin
            m_evt = 1'b1;
            for (int i = 15; i >= 0; i--) if (rise[i]) m_code = 4'(i);
          end
        end
      end
    end
    p2 = p1;
    p1 = mat;
  endtask

  task automatic step();
    logic [3:0] ec;
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
    ec = ~(4'b0001 << ((n / SD) % 4));
    chk("cols", 32'(cols), 32'(ec));
    chk("keys", 32'(keys), 32'(m_keys));
    chk("any_key", 32'(any_key), 32'(m_any));
    chk("key_event", 32'(key_event), 32'(m_evt));
    chk("key_code", 32'(key_code), 32'(m_code));
    if (key_event) begin
      evt_cnt++;
      evt_edge = n;
    end
  endtask

  task automatic run(input int k);
    repeat (k) step();
  endtask

  initial begin
    int e0;
    logic [3:0] seq [4];
    seq[0] = 4'b1110; seq[1] = 4'b1101;
    seq[2] = 4'b1011; seq[3] = 4'b0111;

    model_reset();
    reset = 1'b1;
    run(3);
    chk("reset_cols", 32'(cols), 32'h0000_000E);
    chk("reset_keys", 32'(keys), 32'h0);

    // Single press at row 1 col 2 from the first cycle
    mat = 16'h0040;
    reset = 1'b0;
    run(60);
    chk("press_evt_cnt", evt_cnt, 1);
    chk("press_evt_edge", evt_edge, 48);
    chk("press_keys", 32'(keys), 32'h0040);
    chk("press_code", 32'(key_code), 32'd6);
    chk("press_any", 32'(any_key), 32'd1);

    // Release
    e0 = evt_cnt;
    mat = '0;
    run(64);
    chk("release_keys", 32'(keys), 32'h0);
    chk("release_any", 32'(any_key), 32'd0);
    chk("release_no_evt", evt_cnt, e0);

    // Bounce on key 0, then a clean hold
    for (int i = 0; i < 5 * FR; i++) begin
      if (i % 6 == 0) mat[0] = ~mat[0];
      step();
    end
    chk("bounce_keys", 32'(keys), 32'h0);
    chk("bounce_no_evt", evt_cnt, e0);
    mat = 16'h0001;
    run(4 * FR);
    chk("hold_keys", 32'(keys), 32'h0001);
    chk("hold_code", 32'(key_code), 32'd0);
    chk("hold_evt_cnt", evt_cnt, e0 + 1);

    // Simultaneous 9 and 3, then add 15
    e0 = evt_cnt;
    mat = 16'h0208;
    run(5 * FR);
    chk("simul_keys", 32'(keys), 32'h0208);
    chk("simul_code", 32'(key_code), 32'd3);
    chk("simul_evt_cnt", evt_cnt, e0 + 1);
    mat = 16'h8208;
    run(5 * FR);
    chk("add15_keys", 32'(keys), 32'h8208);
    chk("add15_code", 32'(key_code), 32'd15);
    chk("add15_evt_cnt", evt_cnt, e0 + 2);

    // Reset mid-frame with keys held
    run(7);
    reset = 1'b1;
    #1;
    chk("midrst_cols", 32'(cols), 32'h0000_000E);
    chk("midrst_keys", 32'(keys), 32'h0);
    chk("midrst_any", 32'(any_key), 32'd0);
    chk("midrst_evt", 32'(key_event), 32'd0);
    chk("midrst_code", 32'(key_code), 32'd0);
    model_reset();
    run(2);
    reset = 1'b0;
    e0 = evt_cnt;
    run(40);
    chk("rst_no_early_evt", evt_cnt, e0);
    chk("rst_early_keys", 32'(keys), 32'h0);
    run(20);
    chk("rst_relearn_keys", 32'(keys), 32'h8208);
    chk("rst_relearn_code", 32'(key_code), 32'd3);
    chk("rst_relearn_evt", evt_cnt, e0 + 1);

    // Column walk with nothing pressed
    mat = '0;
    reset = 1'b1;
    model_reset();
    run(2);
    reset = 1'b0;
    for (int i = 1; i <= 5 * SD; i++) begin
      step();
      chk("walk_cols", 32'(cols), 32'(seq[(i / SD) % 4]));
      chk("walk_onehot", $countones(~cols), 1);
    end

    // Random key maps with occasional single-key bounce
    for (int it = 0; it < 24; it++) begin
      int hold;
      mat = 16'($urandom & $urandom);
      hold = $urandom_range(1, 5) * FR;
      for (int k = 0; k < hold; k++) begin
        if ($urandom_range(0, 15) == 0)
          mat = mat ^ (16'h0001 << $urandom_range(0, 15));
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
